manual_state_ctrl: RTL and testbench
====================================

MANUAL_STATE_CTRL -- requirements
Module: manual_state_ctrl

Interface
REQ-001 SHALL have parameter SEC_CYCLES, default 100_000_000, meaning clock cycles per second.
REQ-002 SHALL have parameter HOLD_CYCLES, default 100_000_000, meaning the power-button hold time for power-on.
REQ-003 SHALL have parameter IDLE_CYCLES, default 1_000_000_000, meaning the idle time in NSTART before auto power-off.
REQ-004 SHALL have parameter BLINK_HALF, default 50_000_000, meaning the turn-LED half period in cycles.
REQ-005 SHALL have port clk  input  1  system clock; one clock only, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port power_btn  input  1  power push-button, already debounced, 1 = pressed.
REQ-008 SHALL have port next_power  input  1  requested power from the manual next-state logic (0 = POFF).
REQ-009 SHALL have port next_state  input  2  requested car state: 00 NSTART, 01 START, 10 MOVING.
REQ-010 SHALL have port next_moving_state  input  4  requested motion: 0000 none, 0001 forward, 0010 back, 0100 left, 1000 right.
REQ-011 SHALL have port turn_left_req, turn_right_req  input  1 each  turn-light requests from the next-state logic.
REQ-012 SHALL have port power  output  1  registered power state, fed back to the next-state logic.
REQ-013 SHALL have port state  output  2  registered car state, fed back.
REQ-014 SHALL have port moving_state  output  4  registered motion state, fed back.
REQ-015 SHALL have port turn_left_led, turn_right_led  output  1 each  blinking turn indicators.
REQ-016 SHALL have port mileage  output  14  odometer in seconds of motion, range 0..9999.

Function
REQ-017 Power-off (power=0): state SHALL be 00 and moving_state SHALL be 0000, both LEDs SHALL be 0, and next_* inputs SHALL be ignored.
REQ-018 Power-on: a hold counter SHALL count cycles while power=0 and power_btn=1, clearing whenever power_btn=0; on reaching HOLD_CYCLES, the next cycle SHALL set power=1, state=00, moving_state=0000.
REQ-019 Button edge: power_btn SHALL be registered; a rising edge (prev=0, now=1) while power=1 SHALL set power=0 on the next edge; the button still held from power-on SHALL NOT generate an edge until released.
REQ-020 While power=1, with no off condition pending, the block SHALL load power<=next_power, state<=next_state, moving_state<=next_moving_state every cycle (1-cycle latency).
REQ-021 next_power=0 while power=1 SHALL force power=0, state=00, moving_state=0000 on the next cycle.
REQ-022 Idle timer: SHALL count while power=1 and state=00, SHALL clear when state!=00 or power=0, and SHALL force power-off on the cycle after reaching IDLE_CYCLES.
REQ-023 Off-condition priority: button edge, next_power=0 and idle timeout SHALL all yield the same power-off result; simultaneous occurrence SHALL yield a single power-off with no other effect.
REQ-024 Blink: a phase counter SHALL run while power=1 and toggle a blink bit every BLINK_HALF cycles, and SHALL be cleared (blink=0) while power=0.
REQ-025 LEDs: turn_x_led SHALL equal turn_x_req AND blink, registered; both requests high (NSTART hazard) SHALL blink both in phase.
REQ-026 Odometer: a seconds counter SHALL count while power=1, state=10 and moving_state!=0000, SHALL hold otherwise (fraction retained), and on reaching SEC_CYCLES SHALL wrap to 0 and increment mileage.
REQ-027 mileage SHALL wrap 9999 -> 0, SHALL be retained across power-off, and SHALL be cleared only by rst.
REQ-028 Unused next_state=11 SHALL be loaded as 00.

Reset
REQ-029 rst=1 at a clock edge SHALL set power=0, state=00, moving_state=0000, both LEDs=0, mileage=0, and clear all counters, prev-button and blink registers, overriding all other inputs including mid-hold or mid-motion.

Verification (SEC_CYCLES=10, HOLD_CYCLES=10, IDLE_CYCLES=100, BLINK_HALF=5)
REQ-030 Bench SHALL cover power-on: power_btn held 9 cycles then released -> power stays 0; held 12 cycles -> power=1, state=00 at cycle 11, no power-off when the button is later released.
REQ-031 Bench SHALL cover power-off edge: powered on, button released then pressed 1 cycle -> power=0, state=00, LEDs=0 next cycle.
REQ-032 Bench SHALL cover idle timeout: powered on, next_state=00 held -> power=0 after 101 cycles; next_state=01 at cycle 50 -> no timeout.
REQ-033 Bench SHALL cover the odometer: next_state=10, next_moving_state=0001 for 35 cycles -> mileage=3; mileage preloaded via 9999 seconds of motion, then 10 more cycles -> mileage=0.
REQ-034 Bench SHALL cover blink: turn_left_req=1, turn_right_req=0 -> left LED toggles every 5 cycles, right LED=0; both requests high -> both LEDs toggle together.
REQ-035 Bench SHALL cover reset during motion: rst asserted for 1 cycle while moving with mileage=7 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/manual_state_ctrl.sv
// Car state register block: power-button sequencing, idle auto-off,
// turn-indicator blinking and a seconds-of-motion odometer.
module manual_state_ctrl #(
   parameter int unsigned SEC_CYCLES  = 100_000_000,
   parameter int unsigned HOLD_CYCLES = 100_000_000,
   parameter int unsigned IDLE_CYCLES = 1_000_000_000,
   parameter int unsigned BLINK_HALF  = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        power_btn,
   input  logic        next_power,
   input  logic [1:0]  next_state,
   input  logic [3:0]  next_moving_state,
   input  logic        turn_left_req,
   input  logic        turn_right_req,
   output logic        power,
   output logic [1:0]  state,
   output logic [3:0]  moving_state,
   output logic        turn_left_led,
   output logic        turn_right_led,
   output logic [13:0] mileage
);

   typedef enum logic [1:0] {
      ST_NSTART = 2'b00,
      ST_START  = 2'b01,
      ST_MOVING = 2'b10
   } car_state_e;

   localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned IDLE_W  = $clog2(IDLE_CYCLES + 1);
   localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
   localparam int unsigned SEC_W   = $clog2(SEC_CYCLES + 1);
   localparam int unsigned MILE_W  = 14;
   localparam logic [MILE_W-1:0] MILEAGE_MAX = MILE_W'(9999);

   logic                power_q, power_d;
   car_state_e          state_q, state_d;
   logic [3:0]          mov_q, mov_d;
   logic                btn_prev_q;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_q, blink_d;
   logic                led_l_q, led_l_d;
   logic                led_r_q, led_r_d;
   logic [SEC_W-1:0]    sec_q, sec_d;
   logic [MILE_W-1:0]   mileage_q, mileage_d;

   logic btn_edge_c, off_c, power_on_c, moving_c;

   // Next-state logic for power/state, timers, LEDs and odometer
   always_comb begin
      power_d     = power_q;
      state_d     = state_q;
      mov_d       = mov_q;
      hold_d      = '0;
      idle_d      = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      led_l_d     = 1'b0;
      led_r_d     = 1'b0;
      sec_d       = sec_q;
      mileage_d   = mileage_q;

      btn_edge_c = power_btn & ~btn_prev_q;
      off_c      = power_q & (btn_edge_c | ~next_power |
                              (idle_q >= IDLE_W'(IDLE_CYCLES)));
      power_on_c = ~power_q & (hold_q >= HOLD_W'(HOLD_CYCLES));
      moving_c   = power_q & (state_q == ST_MOVING) & (mov_q != 4'b0000);

      if (!power_q) begin
         state_d = ST_NSTART;
         mov_d   = 4'b0000;
         if (power_on_c) begin
            power_d = 1'b1;
         end else if (power_btn) begin
            hold_d = hold_q + HOLD_W'(1);
         end
      end else if (off_c) begin
         // All off causes collapse into one identical shutdown
         power_d = 1'b0;
         state_d = ST_NSTART;
         mov_d   = 4'b0000;
      end else begin
         power_d = 1'b1;
         state_d = (next_state == 2'b11) ? ST_NSTART : car_state_e'(next_state);
         mov_d   = next_moving_state;
         idle_d  = (state_q == ST_NSTART) ? idle_q + IDLE_W'(1) : '0;
         if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            blink_d     = blink_q;
         end
         led_l_d = turn_left_req  & blink_q;
         led_r_d = turn_right_req & blink_q;
      end

      // Odometer keeps its fraction across stops and power-off
      if (moving_c) begin
         if (sec_q == SEC_W'(SEC_CYCLES - 1)) begin
            sec_d     = '0;
            mileage_d = (mileage_q == MILEAGE_MAX) ? '0 : mileage_q + MILE_W'(1);
         end else begin
            sec_d = sec_q + SEC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         power_q     <= 1'b0;
         state_q     <= ST_NSTART;
         mov_q       <= 4'b0000;
         btn_prev_q  <= 1'b0;
         hold_q      <= '0;
         idle_q      <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         led_l_q     <= 1'b0;
         led_r_q     <= 1'b0;
         sec_q       <= '0;
         mileage_q   <= '0;
      end else begin
         power_q     <= power_d;
         state_q     <= state_d;
         mov_q       <= mov_d;
         btn_prev_q  <= power_btn;
         hold_q      <= hold_d;
         idle_q      <= idle_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         led_l_q     <= led_l_d;
         led_r_q     <= led_r_d;
         sec_q       <= sec_d;
         mileage_q   <= mileage_d;
      end
   end

   assign power          = power_q;
   assign state          = state_q;
   assign moving_state   = mov_q;
   assign turn_left_led  = led_l_q;
   assign turn_right_led = led_r_q;
   assign mileage        = mileage_q;

endmodule

// File: tb/tb_manual_state_ctrl.sv
// Bench for manual_state_ctrl: behavioural reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_manual_state_ctrl;

   localparam int unsigned SEC   = 10;
   localparam int unsigned HOLD  = 10;
   localparam int unsigned IDLE  = 100;
   localparam int unsigned BHALF = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn, np, tl, tr;
   logic [1:0]  ns;
   logic [3:0]  nm;
   logic        power, led_l, led_r;
   logic [1:0]  state;
   logic [3:0]  mov;
   logic [13:0] mileage;

   logic        f_btn, f_np, f_tl, f_tr;
   logic [1:0]  f_ns;
   logic [3:0]  f_nm;
   logic        f_power, f_led_l, f_led_r;
   logic [1:0]  f_state;
   logic [3:0]  f_mov;
   logic [13:0] f_mileage;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   manual_state_ctrl #(.SEC_CYCLES(SEC), .HOLD_CYCLES(HOLD),
                       .IDLE_CYCLES(IDLE), .BLINK_HALF(BHALF)) u_dut (
      .clk(clk), .rst(rst), .power_btn(btn), .next_power(np),
      .next_state(ns), .next_moving_state(nm),
      .turn_left_req(tl), .turn_right_req(tr),
      .power(power), .state(state), .moving_state(mov),
      .turn_left_led(led_l), .turn_right_led(led_r), .mileage(mileage));

   // Second instance with a 2-cycle second so the 9999 -> 0 wrap is reachable
   manual_state_ctrl #(.SEC_CYCLES(2), .HOLD_CYCLES(HOLD),
                       .IDLE_CYCLES(IDLE), .BLINK_HALF(BHALF)) u_fast (
      .clk(clk), .rst(rst), .power_btn(f_btn), .next_power(f_np),
      .next_state(f_ns), .next_moving_state(f_nm),
      .turn_left_req(f_tl), .turn_right_req(f_tr),
      .power(f_power), .state(f_state), .moving_state(f_mov),
      .turn_left_led(f_led_l), .turn_right_led(f_led_r), .mileage(f_mileage));

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: counts of consecutive cycles / total cycles
   bit          m_valid = 1'b0;
   logic        m_power, m_prev, m_ll, m_lr;
   logic [1:0]  m_state;
   logic [3:0]  m_mov;
   int unsigned m_hold, m_idle, m_on, m_motion;

   initial begin : model
      bit off, blink;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_power = 0; m_state = 0; m_mov = 0; m_ll = 0; m_lr = 0; m_prev = 0;
            m_hold = 0; m_idle = 0; m_on = 0; m_motion = 0;
         end else begin
            if (!m_power) begin
               if (m_hold >= HOLD) begin
                  m_power = 1; m_hold = 0;
               end else begin
                  m_hold = btn ? m_hold + 1 : 0;
               end
               m_state = 0; m_mov = 0; m_ll = 0; m_lr = 0; m_idle = 0; m_on = 0;
            end else begin
               off = (btn && !m_prev) || !np || (m_idle >= IDLE);
               if (m_state == 2'd2 && m_mov != 0) m_motion++;
               if (off) begin
                  m_power = 0; m_state = 0; m_mov = 0; m_ll = 0; m_lr = 0;
                  m_idle = 0; m_on = 0;
               end else begin
                  blink = ((m_on / BHALF) % 2) == 1;
                  m_ll = tl & blink;
                  m_lr = tr & blink;
                  m_on++;
                  m_idle = (m_state == 0) ? m_idle + 1 : 0;
                  m_state = (ns == 2'd3) ? 2'd0 : ns;
                  m_mov = nm;
               end
            end
            m_prev = btn;
         end
         m_valid = 1'b1;
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("power",    power,   m_power);
            chk("state",    state,   m_state);
            chk("moving",   mov,     m_mov);
            chk("led_l",    led_l,   m_ll);
            chk("led_r",    led_r,   m_lr);
            chk("mileage",  mileage, (m_motion / SEC) % 10000);
         end
      end
   end

   task automatic power_on();
      btn = 1; step(11);
      btn = 0; step(1);
   endtask

   initial begin : stim
      int unsigned btn_left;
      rst = 1; btn = 0; np = 1; ns = 0; nm = 0; tl = 0; tr = 0;
      f_btn = 0; f_np = 0; f_ns = 0; f_nm = 0; f_tl = 0; f_tr = 0;
      step(2);
      chk("rst_power", power, 0);
      chk("rst_mileage", mileage, 0);
      rst = 0;

      // Short hold does nothing; long hold powers on at the 11th edge
      btn = 1; step(9);
      btn = 0; step(2);
      chk("short_hold", power, 0);
      btn = 1; step(10);
      chk("hold10_off", power, 0);
      step(1);
      chk("hold11_on", power, 1);
      chk("hold11_state", state, 0);
      step(1);
      btn = 0; step(3);
      chk("release_keeps_on", power, 1);

      // Fresh press while on powers off
      btn = 1; step(1);
      chk("edge_off_power", power, 0);
      chk("edge_off_state", state, 0);
      chk("edge_off_leds", {led_l, led_r}, 0);
      btn = 0; step(2);

      // Idle timeout after 101 cycles in NSTART
      power_on();
      step(99);
      chk("idle_100", power, 1);
      step(1);
      chk("idle_101", power, 0);

      // Leaving NSTART at cycle 50 cancels timeout
      power_on();
      step(48);
      ns = 1; step(1);
      step(100);
      chk("no_timeout_power", power, 1);
      chk("no_timeout_state", state, 1);

      np = 0; step(1);
      chk("np0_off", power, 0);
      np = 1;

      // Blink: left alone, then both in phase
      tl = 1; tr = 0;
      power_on();
      for (int k = 2; k <= 21; k++) begin
         step(1);
         chk("blink_left", led_l, ((k - 1) / 5) % 2);
         chk("blink_right_off", led_r, 0);
      end
      tr = 1;
      for (int k = 22; k <= 41; k++) begin
         step(1);
         chk("hazard_l", led_l, ((k - 1) / 5) % 2);
         chk("hazard_r", led_r, ((k - 1) / 5) % 2);
      end
      tl = 0; tr = 0;

      // Odometer: 35 motion cycles -> 3 seconds
      ns = 2; nm = 4'b0001; step(35);
      ns = 0; nm = 0; step(2);
      chk("odo_3", mileage, 3);
      ns = 2; nm = 4'b0001; step(40);
      chk("odo_7", mileage, 7);
      chk("moving_state", mov, 1);

      // Reset mid-motion clears everything
      rst = 1; step(1);
      chk("rst_mid_power", power, 0);
      chk("rst_mid_state", state, 0);
      chk("rst_mid_mov", mov, 0);
      chk("rst_mid_leds", {led_l, led_r}, 0);
      chk("rst_mid_mileage", mileage, 0);
      rst = 0;

      // Random traffic checked by the model
      btn_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (btn_left == 0) begin
            btn = ($urandom_range(0, 2) == 0);
            btn_left = btn ? $urandom_range(1, 14) : $urandom_range(1, 30);
         end
         btn_left--;
         np = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 39) == 0) begin
            ns = 2'($urandom_range(0, 3));
            nm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'(1 << $urandom_range(0, 3));
         end
         tl = 1'($urandom_range(0, 1));
         tr = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 699) == 0);
         step(1);
      end
      rst = 0; btn = 0;

      // Mileage wrap on the fast instance
      f_np = 1; f_btn = 1; step(11);
      chk("fast_on", f_power, 1);
      f_btn = 0; f_ns = 2; f_nm = 4'b0001; step(19998);
      f_ns = 0; f_nm = 0; step(1);
      chk("fast_9999", f_mileage, 9999);
      step(2);
      chk("fast_hold_9999", f_mileage, 9999);
      f_ns = 2; f_nm = 4'b0001; step(2);
      f_ns = 0; f_nm = 0; step(1);
      chk("fast_wrap_0", f_mileage, 0);
      chk("fast_still_on", f_power, 1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
